// File: rtl/aes_key_expand_pkg.sv
// aes_key_expand_pkg -- shared AES-128 constants, FSM state type and Rcon table.
// Revision 1.0
`default_nettype none

package aes_key_expand_pkg;

  localparam int NR       = 10;
  localparam int BLOCK_W  = 128;
  localparam int NUM_KEYS = NR + 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  // Indexed by round number; entry 0 and 11..15 are never used by a real round.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_expand_sbox.sv
// aes_sbox -- 8-bit combinational forward AES S-box (GF(2^8) inverse + affine map).
// Revision 1.0
`default_nettype none

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv      = gf_inv(in_byte);
    out_byte = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
  end

endmodule

`default_nettype wire

// File: rtl/aes_key_expand.sv
// aes_key_expand -- AES-128 key schedule: one round key per cycle, 11-entry round-key store.
// Revision 1.0
`default_nettype none

module aes_key_expand
  import aes_key_expand_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BLOCK_W-1:0]  key_in,
  output logic                busy,
  output logic                rk_valid,
  output logic [3:0]          rk_idx,
  output logic [BLOCK_W-1:0]  rk_data,
  output logic                done,
  output logic                keys_ready,
  input  logic [3:0]          rd_idx,
  output logic [BLOCK_W-1:0]  rd_key
);

  state_t             state;
  state_t             next_state;
  logic [BLOCK_W-1:0] cur_key;
  logic [BLOCK_W-1:0] next_key;
  logic [3:0]         idx;
  logic [3:0]         next_idx;
  logic [BLOCK_W-1:0] store [0:NUM_KEYS-1];
  logic [31:0]        rot;
  logic [31:0]        sub;
  logic [31:0]        t;
  logic [31:0]        w0n, w1n, w2n, w3n;
  logic               accept;
  logic               last;

  assign accept = (state == IDLE) && start;
  assign last   = (state == EXPAND) && (idx == 4'(NR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (accept)    next_state = EXPAND;
    else if (last) next_state = IDLE;
  end

  // SubWord(RotWord(w3)) from four S-box lanes.
  assign rot = rot_word(cur_key[31:0]);

  generate
    for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (rot[8*i +: 8]),
        .out_byte (sub[8*i +: 8])
      );
    end
  endgenerate

  always_comb begin
    next_idx = idx + 4'd1;
    t        = sub ^ {RCON[next_idx], 24'h000000};
    w0n      = cur_key[127:96] ^ t;
    w1n      = cur_key[95:64]  ^ w0n;
    w2n      = cur_key[63:32]  ^ w1n;
    w3n      = cur_key[31:0]   ^ w2n;
    next_key = {w0n, w1n, w2n, w3n};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_key    <= '0;
      idx        <= '0;
      keys_ready <= 1'b0;
      rd_key     <= '0;
      for (int i = 0; i < NUM_KEYS; i++) store[i] <= '0;
    end else begin
      if (accept) begin
        cur_key    <= key_in;
        idx        <= '0;
        keys_ready <= 1'b0;
      end else if (state == EXPAND) begin
        store[idx] <= cur_key;
        cur_key    <= next_key;
        idx        <= last ? 4'd0 : next_idx;
        if (last) keys_ready <= 1'b1;
      end
      // Plain registered read: a same-cycle write is not forwarded.
      rd_key <= (rd_idx < 4'(NUM_KEYS)) ? store[rd_idx] : '0;
    end
  end

  assign busy     = (state == EXPAND);
  assign rk_valid = busy;
  assign rk_idx   = busy ? idx : 4'd0;
  assign rk_data  = busy ? cur_key : '0;
  assign done     = last;

endmodule

`default_nettype wire

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request a new expansion; sampled on the clk edge.
REQ-004 SHALL have port: key_in  input  128  AES-128 cipher key; byte 0 = key_in[127:120], word w0 = key_in[127:96].
REQ-005 SHALL have port: busy  output  1  expansion in progress.
REQ-006 SHALL have port: rk_valid  output  1  rk_idx/rk_data carry a freshly generated round key this cycle.
REQ-007 SHALL have port: rk_idx  output  4  round number 0..10 of rk_data.
REQ-008 SHALL have port: rk_data  output  128  round key, same byte order as key_in; feeds the AddRoundKey stage key input.
REQ-009 SHALL have port: done  output  1  one-cycle pulse coinciding with rk_idx=10.
REQ-010 SHALL have port: keys_ready  output  1  all 11 stored round keys are valid for the last accepted key.
REQ-011 SHALL have port: rd_idx  input  4  stored round key select.
REQ-012 SHALL have port: rd_key  output  128  stored round key, registered, 1-cycle read latency.

Function
REQ-013 SHALL implement FSM states IDLE, EXPAND; reset state IDLE.
REQ-014 IDLE with start=1 SHALL latch key_in, clear keys_ready, and go to EXPAND; start in EXPAND SHALL be ignored (no restart, no latch).
REQ-015 First EXPAND cycle (cycle N+1 after start at edge N) SHALL output rk_valid=1, rk_idx=0, rk_data=latched key.
REQ-016 Each following cycle SHALL output the next round key, idx 1..10 on cycles N+2..N+11, exactly one key per cycle, no gaps.
REQ-017 Round key i SHALL be computed from key i-1 per FIPS-197: t = SubWord(RotWord(w3)) xor Rcon[i]; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-018 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 in the top byte, zero lower bytes.
REQ-019 done SHALL pulse with idx 10; FSM SHALL return to IDLE on the following edge; busy SHALL be 1 exactly during the 11 output cycles.
REQ-020 keys_ready SHALL rise the cycle after done and stay high until the next accepted start or reset.
REQ-021 Each generated key SHALL be written to storage entry rk_idx in its output cycle; 11 x 128-bit entries.
REQ-022 rd_key SHALL equal entry rd_idx one cycle after rd_idx is presented; rd_idx 11..15 SHALL return all zeros.
REQ-023 Reading an entry in the same cycle it is written SHALL return the old contents (no bypass).
REQ-024 start asserted in the done cycle SHALL be ignored; a start in the next (IDLE) cycle SHALL be accepted.
REQ-025 rk_valid=0 SHALL force rk_idx=0 and rk_data=0.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, busy=0, rk_valid=0, rk_idx=0, rk_data=0, done=0, keys_ready=0, rd_key=0, all storage entries and latched key to zero.
REQ-027 rst mid-expansion SHALL abort with no further rk_valid; after release an expansion SHALL require a new start.

Structure
REQ-028 A shared AES package SHALL hold the FSM state type, the Rcon table, and round-count/width constants (NR=10, 128-bit block).
REQ-029 One sub-module aes_sbox (8-bit combinational forward S-box) SHALL be instantiated four times for SubWord.

Verification
REQ-030 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start one cycle -> idx0 = key, idx1 = a0fafe1788542cb123a339392a6c7605, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 on cycle N+11 with done=1.
REQ-031 All-zero key -> idx1 = 62636363626363636263636362636363, idx10 = b4ef5bcb3e92e21123e951cf6f8f188e; keys_ready=1 from N+12.
REQ-032 After REQ-030 completes, rd_idx sweep 0..15 -> rd_key matches each generated key one cycle later; 11..15 give zero.
REQ-033 start held high continuously with changing key_in -> only the key at the first accepted edge is used; back-to-back expansion starts the cycle after done.
REQ-034 rst pulsed at idx 5 -> all outputs zero immediately; no rk_valid until a new start; rd_key of every entry reads zero.
